// File: rtl/store_outcome_checker.sv
// Pass/fail monitor snooping the core's data-memory write bus; decides the test
// outcome from the terminating store, an address whitelist and a cycle timeout.
module store_outcome_checker #(
  parameter int XLEN           = 32,
  parameter int N_ALLOW        = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mem_write,
  input  logic [XLEN-1:0]         data_adr,
  input  logic [XLEN-1:0]         write_data,
  input  logic [XLEN-1:0]         pass_addr,
  input  logic [XLEN-1:0]         pass_data,
  input  logic [N_ALLOW*XLEN-1:0] allow_addr,
  input  logic [N_ALLOW-1:0]      allow_en,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [1:0]              fail_reason,
  output logic [XLEN-1:0]         fail_addr,
  output logic [XLEN-1:0]         fail_data,
  output logic [CNT_W-1:0]        store_count,
  output logic [CNT_W-1:0]        cycle_count
);

  // Dedicated timeout counter so cycle_count saturation never masks the timeout.
  localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, RUN, PASSED, FAILED, TIMEDOUT} state_t;

  state_t        state;
  logic [TW-1:0] toCnt;
  logic          allowHit;
  logic          passAdr;
  logic          toExpire;

  always_comb begin
    allowHit = 1'b0;
    for (int i = 0; i < N_ALLOW; i++)
      if (allow_en[i] && (allow_addr[i*XLEN +: XLEN] == data_adr)) allowHit = 1'b1;
  end

  assign passAdr  = (data_adr == pass_addr);
  assign toExpire = (TIMEOUT_CYCLES != 0) && (toCnt == TW'(TO_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= 2'd0;
      fail_addr   <= '0;
      fail_data   <= '0;
      store_count <= '0;
      cycle_count <= '0;
      toCnt       <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
          if (TIMEOUT_CYCLES != 0) toCnt <= toCnt + 1'b1;
          if (mem_write && store_count != CNT_MAX) store_count <= store_count + 1'b1;
          // A concluding store takes precedence over a timeout in the same cycle.
          if (mem_write && passAdr) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (write_data == pass_data) begin
              state <= PASSED;
              pass  <= 1'b1;
            end else begin
              state       <= FAILED;
              fail        <= 1'b1;
              fail_reason <= 2'd2;
              fail_addr   <= data_adr;
              fail_data   <= write_data;
            end
          end else if (mem_write && !allowHit) begin
            state       <= FAILED;
            busy        <= 1'b0;
            done        <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= 2'd1;
            fail_addr   <= data_adr;
            fail_data   <= write_data;
          end else if (toExpire) begin
            state       <= TIMEDOUT;
            busy        <= 1'b0;
            done        <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= 2'd3;
          end
        end
        default: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_reason <= 2'd0;
            fail_addr   <= '0;
            fail_data   <= '0;
            store_count <= '0;
            cycle_count <= '0;
            toCnt       <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_outcome_checker.sv
// Bench for store_outcome_checker: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the pass/fail rules.
module tb_store_outcome_checker;

  localparam int XLEN = 32, N_ALLOW = 2, TO = 20, CNT_W = 16;
  localparam int CMAX = 65535;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TO = 4;

  logic clk = 1'b0;
  logic reset, start, memWrite;
  logic [XLEN-1:0] dataAdr, writeData, passAddr, passData;
  logic [XLEN-1:0] allowA [N_ALLOW];
  logic [N_ALLOW*XLEN-1:0] allowAddr;
  logic [N_ALLOW-1:0] allowEn;
  logic busy, done, pass, fail;
  logic [1:0] failReason;
  logic [XLEN-1:0] failAddr, failData;
  logic [CNT_W-1:0] storeCount, cycleCount;

  int checks = 0, errors = 0;

  // Behavioural model state
  int mPhase, mSc, mCc, mRun, mReason;
  logic [XLEN-1:0] mFa, mFd;

  assign allowAddr = {allowA[1], allowA[0]};
  wire [101:0] obs = {busy, done, pass, fail, failReason, failAddr, failData, storeCount, cycleCount};

  always #5 clk = ~clk;

  store_outcome_checker #(.XLEN(XLEN), .N_ALLOW(N_ALLOW), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_write(memWrite), .data_adr(dataAdr),
    .write_data(writeData), .pass_addr(passAddr), .pass_data(passData), .allow_addr(allowAddr),
    .allow_en(allowEn), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_reason(failReason), .fail_addr(failAddr), .fail_data(failData),
    .store_count(storeCount), .cycle_count(cycleCount));

  function automatic logic [101:0] expVec();
    logic b, d, p, f;
    b = (mPhase == M_RUN);
    d = (mPhase == M_PASS) || (mPhase == M_FAIL) || (mPhase == M_TO);
    p = (mPhase == M_PASS);
    f = (mPhase == M_FAIL) || (mPhase == M_TO);
    return {b, d, p, f, 2'(mReason), mFa, mFd, 16'(mSc), 16'(mCc)};
  endfunction

  function automatic bit allowed(input logic [XLEN-1:0] a);
    for (int i = 0; i < N_ALLOW; i++)
      if (allowEn[i] && allowA[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mPhase = M_IDLE; mSc = 0; mCc = 0; mRun = 0; mReason = 0; mFa = '0; mFd = '0;
  endtask

  task automatic modelEdge();
    bit concl;
    if (mPhase == M_RUN) begin
      concl = 1'b0;
      if (memWrite) begin
        mSc = (mSc < CMAX) ? mSc + 1 : CMAX;
        if (dataAdr == passAddr) begin
          concl = 1'b1;
          if (writeData == passData) mPhase = M_PASS;
          else begin mPhase = M_FAIL; mReason = 2; mFa = dataAdr; mFd = writeData; end
        end else if (!allowed(dataAdr)) begin
          concl = 1'b1;
          mPhase = M_FAIL; mReason = 1; mFa = dataAdr; mFd = writeData;
        end
      end
      if (!concl && mRun == TO - 1) begin mPhase = M_TO; mReason = 3; end
      mRun++;
      mCc = (mCc < CMAX) ? mCc + 1 : CMAX;
    end else if (start) begin
      mPhase = M_RUN; mSc = 0; mCc = 0; mRun = 0; mReason = 0; mFa = '0; mFd = '0;
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, and settle for sampling.
  task automatic tick(input logic s, input logic mw, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    start = s; memWrite = mw; dataAdr = a; writeData = d;
    @(posedge clk);
    modelEdge();
    #1;
    start = 1'b0; memWrite = 1'b0;
  endtask

  task automatic setup();
    passAddr = 100; passData = 25; allowA[0] = 96; allowA[1] = 92; allowEn = 2'b01;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 102'd0) begin errors++; $display("FAIL reset_state: got %h expected 0", obs); end
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (obs !== 102'd0) begin errors++; $display("FAIL idle_ignores_store: got %h expected 0", obs); end
  endtask

  task automatic test_pass();
    setup();
    tick(1'b1, 1'b0, 0, 0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL pass_armed: busy %b done %b expected 1 0", busy, done); end
    tick(1'b0, 1'b1, 96, 7);
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || failReason !== 2'd0 || storeCount !== 16'd2) begin
      errors++; $display("FAIL pass_outcome: pass %b done %b busy %b reason %0d sc %0d expected 1 1 0 0 2",
                         pass, done, busy, failReason, storeCount);
    end
    checks++;
    if (obs !== expVec()) begin errors++; $display("FAIL pass_model: got %h expected %h", obs, expVec()); end
  endtask

  task automatic test_unexpected_addr();
    setup();
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 104, 25);
    checks++;
    if (fail !== 1'b1 || failReason !== 2'd1 || failAddr !== 32'd104 || failData !== 32'd25 || storeCount !== 16'd1) begin
      errors++; $display("FAIL unexpected_addr: fail %b reason %0d addr %0d data %0d sc %0d expected 1 1 104 25 1",
                         fail, failReason, failAddr, failData, storeCount);
    end
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (obs !== expVec() || pass !== 1'b0 || cycleCount !== 16'd1) begin
      errors++; $display("FAIL sticky_after_fail: got %h expected %h", obs, expVec());
    end
  endtask

  task automatic test_wrong_data();
    setup();
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 100, 24);
    checks++;
    if (fail !== 1'b1 || failReason !== 2'd2 || failData !== 32'd24 || failAddr !== 32'd100) begin
      errors++; $display("FAIL wrong_data: fail %b reason %0d data %0d addr %0d expected 1 2 24 100",
                         fail, failReason, failData, failAddr);
    end
  endtask

  task automatic test_timeout();
    setup();
    tick(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 1'b0, 0, 0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || cycleCount !== 16'(TO - 1)) begin
      errors++; $display("FAIL timeout_early: done %b busy %b cc %0d expected 0 1 %0d", done, busy, cycleCount, TO - 1);
    end
    tick(1'b0, 1'b0, 0, 0);
    checks++;
    if (fail !== 1'b1 || failReason !== 2'd3 || cycleCount !== 16'(TO) || failAddr !== 32'd0 || failData !== 32'd0) begin
      errors++; $display("FAIL timeout_fire: fail %b reason %0d cc %0d expected 1 3 %0d", fail, failReason, cycleCount, TO);
    end
    tick(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || failReason !== 2'd0 || cycleCount !== 16'(TO)) begin
      errors++; $display("FAIL store_beats_timeout: pass %b fail %b reason %0d cc %0d expected 1 0 0 %0d",
                         pass, fail, failReason, cycleCount, TO);
    end
  endtask

  task automatic test_reset_restart();
    setup();
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 96, 3);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checks++;
    if (obs !== 102'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs); end
    #1 reset = 1'b0;
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (obs !== 102'd0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", obs); end
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 100, 25);
    checks++;
    if (pass !== 1'b1 || storeCount !== 16'd1) begin
      errors++; $display("FAIL restart_pass: pass %b sc %0d expected 1 1", pass, storeCount);
    end
  endtask

  task automatic test_rearm_disabled();
    setup();
    allowEn = 2'b00;
    tick(1'b1, 1'b0, 0, 0);
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || storeCount !== 16'd0 || cycleCount !== 16'd0) begin
      errors++; $display("FAIL rearm_clear: got %h expected %h", obs, expVec());
    end
    tick(1'b1, 1'b1, 96, 1);
    checks++;
    if (fail !== 1'b1 || failReason !== 2'd1 || failAddr !== 32'd96 || failData !== 32'd1) begin
      errors++; $display("FAIL disabled_entry: fail %b reason %0d addr %0d expected 1 1 96", fail, failReason, failAddr);
    end
  endtask

  task automatic test_random();
    logic s, mw;
    logic [XLEN-1:0] a, d;
    logic [XLEN-1:0] pool [4];
    pool[0] = 100; pool[1] = 96; pool[2] = 92; pool[3] = 104;
    setup();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) begin
        #2 reset = 1'b1;
        modelReset();
        #1 reset = 1'b0;
      end
      s  = (mPhase == M_RUN) ? ($urandom_range(19) == 0) : ($urandom_range(3) == 0);
      if (s && mPhase != M_RUN) allowEn = N_ALLOW'($urandom);
      mw = ($urandom_range(3) == 0);
      a  = pool[$urandom_range(3)];
      d  = $urandom_range(1) ? 32'd25 : $urandom;
      tick(s, mw, a, d);
      checks++;
      if (obs !== expVec()) begin errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, expVec()); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; memWrite = 1'b0; dataAdr = '0; writeData = '0;
    setup();
    modelReset();
    #12 reset = 1'b0;
    test_reset();
    test_pass();
    test_unexpected_addr();
    test_wrong_data();
    test_timeout();
    test_reset_restart();
    test_pass();
    test_rearm_disabled();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
